imem_arbiter: RTL and testbench



---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_arb_pick.sv | 64 ++++++
 rtl/imem_arbiter.sv | 83 ++++++++
 tb/tb_imem_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// The owner-state encoding is shared so that other blocks can decode it consistently.
package imem_pkg;

    localparam int IMEM_ADDR_W = 32;
    localparam int IMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        F_OWN = 2'd1,
        D_OWN = 2'd2
    } owner_t;

    // Saturating increment used by the debug starvation counter.
    function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
        return (value >= limit) ? limit : value + 4'd1;
    endfunction

endpackage

// File: rtl/imem_arb_pick.sv
// Grant decision between fetch (F) and debug (D) requesters.
// Defining IMEM_ARB_RR_EN selects 1-bit round-robin; otherwise fixed F priority with a D starvation guard.
module imem_arb_pick
    import imem_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic f_req,
    input  logic d_req,
    output logic f_gnt,
    output logic d_gnt
);

    logic d_win;
    logic f_win;

`ifdef IMEM_ARB_RR_EN
    // 1 = D won the most recent contest, so F takes the next one.
    logic last_winner_reg;

    assign d_win = d_req & (~f_req | ~last_winner_reg);
    assign f_win = f_req & ~d_win;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner_reg <= 1'b1;
        end else if (f_req && d_req) begin
            last_winner_reg <= d_win;
        end
    end
`else
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_reg;
    logic [3:0] wait_cnt_next;
    logic       force_d;

    assign force_d = (wait_cnt_reg == MAX_WAIT_C);
    assign d_win   = d_req & (~f_req | force_d);
    assign f_win   = f_req & ~d_win;

    always_comb begin
        wait_cnt_next = 4'd0;
        if (d_req && !d_gnt) begin
            wait_cnt_next = sat_inc(wait_cnt_reg, MAX_WAIT_C);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_reg <= 4'd0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end
`endif

    // No grants while reset is held, so nothing can be in flight when it releases.
    assign f_gnt = f_win & ~reset;
    assign d_gnt = d_win & ~reset;

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-port synchronous instruction memory between fetch (F) and debug (D).
// Build option IMEM_ARB_RR_EN switches the grant policy to round-robin (see imem_arb_pick).
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W   = IMEM_ADDR_W,
    parameter int DATA_W   = IMEM_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    owner_t            state_reg;
    logic [ADDR_W-1:0] sel_addr;
    logic              f_sel;
    logic              d_sel;

    imem_arb_pick #(
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .clk   (clk),
        .reset (reset),
        .f_req (f_req),
        .d_req (d_req),
        .f_gnt (f_gnt),
        .d_gnt (d_gnt)
    );

    // Owner of the word that the memory returns in the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else if (f_gnt) begin
            state_reg <= F_OWN;
        end else if (d_gnt) begin
            state_reg <= D_OWN;
        end else begin
            state_reg <= IDLE;
        end
    end

    always_comb begin
        sel_addr = '0;
        if (f_gnt) begin
            sel_addr = f_addr;
        end else if (d_gnt) begin
            sel_addr = d_addr;
        end
    end

    assign mem_en   = f_gnt | d_gnt;
    assign mem_addr = sel_addr & WORD_MASK;

    // Reset also suppresses the response of a grant issued just before it.
    assign f_sel    = (state_reg == F_OWN) & ~reset;
    assign d_sel    = (state_reg == D_OWN) & ~reset;
    assign f_rvalid = f_sel;
    assign d_rvalid = d_sel;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_route
            assign f_rdata[gi] = mem_rdata[gi] & f_sel;
            assign d_rdata[gi] = mem_rdata[gi] & d_sel;
        end
    endgenerate

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed vector bench for imem_arbiter with a behavioural one-cycle-latency memory.
// Expectations follow the build: IMEM_ARB_RR_EN selects the round-robin vector set.
module tb_imem_arbiter;

    logic        clk;
    logic        reset;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;

    int tests;
    int fails;

    typedef struct {
        logic        rst;
        logic        fr;
        logic [31:0] fa;
        logic        dr;
        logic [31:0] da;
        logic        fg;
        logic        dg;
        logic        me;
        logic [31:0] ma;
        logic        fv;
        logic [31:0] fd;
        logic        dv;
        logic [31:0] dd;
    } vec_t;

    vec_t vecs[$];

    imem_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] w(input int idx);
        return 32'hC0DE_0000 + 32'(idx);
    endfunction

    // Word i of the memory model is w(i); data appears one cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= w(int'(mem_addr[5:2]));
        end
    end

    function automatic vec_t mk(
        input logic rst, input logic fr, input logic [31:0] fa,
        input logic dr, input logic [31:0] da,
        input logic fg, input logic dg, input logic me, input logic [31:0] ma,
        input logic fv, input logic [31:0] fd, input logic dv, input logic [31:0] dd);
        vec_t v;
        v.rst = rst; v.fr = fr; v.fa = fa; v.dr = dr; v.da = da;
        v.fg = fg; v.dg = dg; v.me = me; v.ma = ma;
        v.fv = fv; v.fd = fd; v.dv = dv; v.dd = dd;
        return v;
    endfunction

    initial begin
        int exp_cycle;
        int got_cycle;
        logic ok;

        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        f_req     = 1'b0;
        f_addr    = '0;
        d_req     = 1'b0;
        d_addr    = '0;
        mem_rdata = '0;

        // Reset, idle after reset, then F-only back-to-back fetches.
        vecs.push_back(mk(1, 1, 8,  1, 40, 0, 0, 0, 0,  0, 0,    0, 0));
        vecs.push_back(mk(1, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0,    0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0,    0, 0));
        vecs.push_back(mk(0, 1, 0,  0, 0,  1, 0, 1, 0,  0, 0,    0, 0));
        vecs.push_back(mk(0, 1, 4,  0, 0,  1, 0, 1, 4,  1, w(0), 0, 0));
        vecs.push_back(mk(0, 1, 8,  0, 0,  1, 0, 1, 8,  1, w(1), 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 0,  1, w(2), 0, 0));
`ifdef IMEM_ARB_RR_EN
        // Contested grants alternate starting with F; uncontested grants do not flip the pointer.
        vecs.push_back(mk(0, 1, 0,  1, 40, 1, 0, 1, 0,  0, 0,    0, 0));
        vecs.push_back(mk(0, 1, 4,  1, 40, 0, 1, 1, 40, 1, w(0), 0, 0));
        vecs.push_back(mk(0, 1, 4,  1, 44, 1, 0, 1, 4,  0, 0,    1, w(10)));
        vecs.push_back(mk(0, 1, 8,  1, 44, 0, 1, 1, 44, 1, w(1), 0, 0));
        vecs.push_back(mk(0, 1, 8,  0, 0,  1, 0, 1, 8,  0, 0,    1, w(11)));
        vecs.push_back(mk(0, 1, 12, 1, 16, 1, 0, 1, 12, 1, w(2), 0, 0));
        vecs.push_back(mk(0, 0, 0,  1, 16, 0, 1, 1, 16, 1, w(3), 0, 0));
        vecs.push_back(mk(0, 1, 20, 1, 24, 0, 1, 1, 24, 0, 0,    1, w(4)));
        vecs.push_back(mk(0, 1, 20, 0, 0,  1, 0, 1, 20, 0, 0,    1, w(6)));
        vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 0,  1, w(5), 0, 0));
`else
        // F held, D requesting from cycle 0: D forced on the fifth cycle.
        vecs.push_back(mk(0, 1, 16, 1, 40, 1, 0, 1, 16, 0, 0,    0, 0));
        vecs.push_back(mk(0, 1, 20, 1, 40, 1, 0, 1, 20, 1, w(4), 0, 0));
        vecs.push_back(mk(0, 1, 24, 1, 40, 1, 0, 1, 24, 1, w(5), 0, 0));
        vecs.push_back(mk(0, 1, 28, 1, 40, 1, 0, 1, 28, 1, w(6), 0, 0));
        vecs.push_back(mk(0, 1, 32, 1, 40, 0, 1, 1, 40, 1, w(7), 0, 0));
        vecs.push_back(mk(0, 1, 32, 0, 0,  1, 0, 1, 32, 0, 0,    1, w(10)));
        vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 0,  1, w(8), 0, 0));
        // D dropping its request clears the wait count, delaying the forced grant.
        vecs.push_back(mk(0, 1, 0,  1, 44, 1, 0, 1, 0,  0, 0,    0, 0));
        vecs.push_back(mk(0, 1, 4,  1, 44, 1, 0, 1, 4,  1, w(0), 0, 0));
        vecs.push_back(mk(0, 1, 8,  0, 0,  1, 0, 1, 8,  1, w(1), 0, 0));
        vecs.push_back(mk(0, 1, 12, 1, 44, 1, 0, 1, 12, 1, w(2), 0, 0));
        vecs.push_back(mk(0, 1, 16, 1, 44, 1, 0, 1, 16, 1, w(3), 0, 0));
        vecs.push_back(mk(0, 1, 20, 1, 44, 1, 0, 1, 20, 1, w(4), 0, 0));
        vecs.push_back(mk(0, 1, 24, 1, 44, 1, 0, 1, 24, 1, w(5), 0, 0));
        vecs.push_back(mk(0, 1, 28, 1, 44, 0, 1, 1, 44, 1, w(6), 0, 0));
        vecs.push_back(mk(0, 1, 28, 0, 0,  1, 0, 1, 28, 0, 0,    1, w(11)));
        vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 0,  1, w(7), 0, 0));
`endif
        // Unaligned address, reset right after a grant, dropped request, D-only access.
        vecs.push_back(mk(0, 1, 7,  0, 0,  1, 0, 1, 4,  0, 0,    0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 0,  1, w(1), 0, 0));
        vecs.push_back(mk(0, 1, 12, 0, 0,  1, 0, 1, 12, 0, 0,    0, 0));
        vecs.push_back(mk(1, 1, 12, 0, 0,  0, 0, 0, 0,  0, 0,    0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0,    0, 0));
        vecs.push_back(mk(0, 1, 0,  1, 8,  1, 0, 1, 0,  0, 0,    0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 0,  1, w(0), 0, 0));
        vecs.push_back(mk(0, 0, 0,  1, 12, 0, 1, 1, 12, 0, 0,    0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0,    1, w(3)));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            reset  = vecs[i].rst;
            f_req  = vecs[i].fr;
            f_addr = vecs[i].fa;
            d_req  = vecs[i].dr;
            d_addr = vecs[i].da;
            @(negedge clk);
            tests++;
            ok = (f_gnt === vecs[i].fg) && (d_gnt === vecs[i].dg) &&
                 (mem_en === vecs[i].me) && (mem_addr === vecs[i].ma) &&
                 (f_rvalid === vecs[i].fv) && (f_rdata === vecs[i].fd) &&
                 (d_rvalid === vecs[i].dv) && (d_rdata === vecs[i].dd);
            if (!ok) begin
                fails++;
                $display("[TB] FAIL vec%0d: got fg=%b dg=%b me=%b ma=%h fv=%b fd=%h dv=%b dd=%h, required fg=%b dg=%b me=%b ma=%h fv=%b fd=%h dv=%b dd=%h",
                         i, f_gnt, d_gnt, mem_en, mem_addr, f_rvalid, f_rdata, d_rvalid, d_rdata,
                         vecs[i].fg, vecs[i].dg, vecs[i].me, vecs[i].ma,
                         vecs[i].fv, vecs[i].fd, vecs[i].dv, vecs[i].dd);
            end else begin
                $display("[TB] vec%0d ok: fg=%b dg=%b ma=%h fv=%b dv=%b", i, f_gnt, d_gnt, mem_addr, f_rvalid, d_rvalid);
            end
        end

        // Both requesters held with no prior D wait: measure the cycle of the first D grant.
`ifdef IMEM_ARB_RR_EN
        exp_cycle = 0;
`else
        exp_cycle = 4;
`endif
        got_cycle = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            f_req  = 1'b1;
            f_addr = 32'd0;
            d_req  = 1'b1;
            d_addr = 32'd36;
            @(negedge clk);
            if (d_gnt) begin
                got_cycle = k;
                break;
            end
        end
        tests++;
        if (got_cycle != exp_cycle || f_gnt !== 1'b0) begin
            fails++;
            $display("[TB] FAIL d_wait: got d_gnt cycle=%0d f_gnt=%b, required cycle=%0d f_gnt=0", got_cycle, f_gnt, exp_cycle);
        end else begin
            $display("[TB] d_wait ok: d_gnt in cycle %0d", got_cycle);
        end

        @(posedge clk);
        #1;
        d_req = 1'b0;
        @(negedge clk);
        tests++;
        if (d_rvalid !== 1'b1 || d_rdata !== w(9) || f_gnt !== 1'b1 || f_rvalid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL d_return: got dv=%b dd=%h fg=%b fv=%b, required dv=1 dd=%h fg=1 fv=0",
                     d_rvalid, d_rdata, f_gnt, f_rvalid, w(9));
        end else begin
            $display("[TB] d_return ok: dd=%h", d_rdata);
        end

        @(posedge clk);
        #1;
        f_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (f_rvalid !== 1'b0 || f_gnt !== 1'b0 || mem_en !== 1'b0 || f_rdata !== 32'd0) begin
            fails++;
            $display("[TB] FAIL final_reset: got fv=%b fg=%b me=%b fd=%h, required all 0", f_rvalid, f_gnt, mem_en, f_rdata);
        end else begin
            $display("[TB] final_reset ok");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
